// File: rtl/ahb_dma_peri_slave.sv
// ahb_dma_peri_slave
//   AHB-Lite responder that models a DMA-capable peripheral. It holds a
//   word-addressed data RAM (offset 0x00 .. 4*MEM_WORDS-1), four descriptor
//   registers at 0xA0 (SAddr), 0xA4 (DAddr), 0xA8 (Size) and 0xAC (Ctrl), and
//   a DMA request flag raised by the peripheral and cleared when the DMAC
//   reads Ctrl.
//
//   Build option: define AHB_DMA_PERI_SLAVE_ERR_EN to answer illegal
//   transfers with the two-cycle ERROR response. Without it, illegal
//   transfers complete OKAY (with wait states), writes are dropped, reads
//   return 0 and HResp is tied to OKAY.
//
// Parameters
//   MEM_WORDS    data RAM depth in 32-bit words (4*MEM_WORDS <= 0xA0)
//   WAIT_STATES  HReadyOut-low cycles in every OKAY data phase (0..15)
//
// Ports
//   clk, rst           clock, asynchronous active-high reset
//   HSel .. HReadyIn   AHB-Lite address/data phase inputs (HAddr[7:0] decoded)
//   HReadyOut, HResp   transfer completion / response
//   HRData             read data, non-zero only in the completing read cycle
//   peri_trig          peripheral data-ready pulse
//   DmaReq             DMA request to the DMAC
module ahb_dma_peri_slave #(
  parameter int MEM_WORDS   = 40,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        HSel,
  input  logic [31:0] HAddr,
  input  logic [1:0]  HTrans,
  input  logic        HWrite,
  input  logic [1:0]  HSize,
  input  logic [31:0] HWData,
  input  logic [3:0]  HWStrb,
  input  logic        HReadyIn,
  output logic        HReadyOut,
  output logic [1:0]  HResp,
  output logic [31:0] HRData,
  input  logic        peri_trig,
  output logic        DmaReq
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [8:0] RAM_END = 9'(4 * MEM_WORDS);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t      state, nstate;
  logic [3:0]  cnt, cnt_n;
  logic [7:0]  addr_q;
  logic        write_q, err_q;
  logic [31:0] mem [MEM_WORDS];
  logic [31:0] desc [4];

  logic [7:0]  a_in;
  logic        err_in, err_path, accept, can_accept;
  logic        ram_hit, desc_hit, we, ctrl_rd_done;
  logic [AW-1:0] widx;
  logic [31:0] rdata;

  // Upper address bits and the BUSY/SEQ distinction carry no meaning here.
  logic unused;
  assign unused = &{1'b0, HAddr[31:8], HTrans[0]};

  assign a_in = HAddr[7:0];

  // Illegal size, misalignment, past the descriptor block, or in the hole
  // between the end of RAM and the descriptors.
  assign err_in = (HSize == 2'b11)
               || (HSize == 2'b01 && a_in[0])
               || (HSize == 2'b10 && a_in[1:0] != 2'b00)
               || (a_in >= 8'hB0)
               || ({1'b0, a_in} >= RAM_END && a_in <= 8'h9F);

`ifdef AHB_DMA_PERI_SLAVE_ERR_EN
  assign err_path = err_in;
`else
  assign err_path = 1'b0;
`endif

  assign accept     = HSel & HReadyIn & HTrans[1];
  assign can_accept = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);

  // State register and address-phase capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= nstate;
      cnt   <= cnt_n;
      if (can_accept && accept) begin
        addr_q  <= a_in;
        write_q <= HWrite;
        err_q   <= err_in;
      end
    end
  end

  // Next state and handshake
  always_comb begin
    nstate    = state;
    cnt_n     = cnt;
    HReadyOut = 1'b1;
    case (state)
      S_WAIT: begin
        HReadyOut = 1'b0;
        if (cnt == 4'd0) nstate = S_DONE;
        else             cnt_n  = cnt - 4'd1;
      end
      S_ERR1: begin
        HReadyOut = 1'b0;
        nstate    = S_ERR2;
      end
      default: ;
    endcase
    // A completing (or idle) cycle may take the next address phase directly.
    if (can_accept) begin
      nstate = S_IDLE;
      if (accept) begin
        if (err_path) begin
          nstate = S_ERR1;
        end else if (WAIT_STATES > 0) begin
          nstate = S_WAIT;
          cnt_n  = 4'(WAIT_STATES - 1);
        end else begin
          nstate = S_DONE;
        end
      end
    end
  end

`ifdef AHB_DMA_PERI_SLAVE_ERR_EN
  assign HResp = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
`else
  assign HResp = 2'b00;
`endif

  // Data phase decode (err_q guarantees alignment and range when clear)
  assign widx     = addr_q[AW+1:2];
  assign ram_hit  = ({1'b0, addr_q} < RAM_END);
  assign desc_hit = (addr_q[7:4] == 4'hA);
  assign we       = (state == S_DONE) && write_q && !err_q;

  // RAM has no reset; state is reset asynchronously, so an aborted
  // transfer can never reach the S_DONE write.
  always_ff @(posedge clk) begin
    if (we && ram_hit)
      for (int i = 0; i < 4; i++)
        if (HWStrb[i]) mem[widx][8*i +: 8] <= HWData[8*i +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 4; r++) desc[r] <= '0;
    end else if (we && desc_hit) begin
      for (int i = 0; i < 4; i++)
        if (HWStrb[i]) desc[addr_q[3:2]][8*i +: 8] <= HWData[8*i +: 8];
    end
  end

  // Reads sample storage in their own completing cycle, so a write that
  // completed on the accepting edge is already visible (forwarding).
  always_comb begin
    rdata = '0;
    if (ram_hit)       rdata = mem[widx];
    else if (desc_hit) rdata = desc[addr_q[3:2]];
  end

  assign HRData = (state == S_DONE && !write_q && !err_q) ? rdata : 32'h0;

  // DMA request: set by the peripheral, cleared by an OKAY read of Ctrl;
  // a simultaneous set wins.
  assign ctrl_rd_done = (state == S_DONE) && !write_q && !err_q
                        && (addr_q[7:2] == 6'h2B);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) DmaReq <= 1'b0;
    else     DmaReq <= peri_trig | (DmaReq & ~ctrl_rd_done);
  end

endmodule

// File: tb/tb_ahb_dma_peri_slave.sv
// Bench for ahb_dma_peri_slave: two instances (0 and 2 wait states) share
// one AHB bus; sel picks the addressed instance. Stimulus pushes the
// expected response, a monitor pops it when the data phase completes.
module tb_ahb_dma_peri_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        hsel, sel, hwrite, peri_trig;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans, hsize;
  logic [3:0]  hwstrb;
  logic        ro0, ro2, dma0, dma2;
  logic [1:0]  rsp0, rsp2;
  logic [31:0] rd0, rd2;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  assign hready = sel ? ro2  : ro0;
  assign hresp  = sel ? rsp2 : rsp0;
  assign hrdata = sel ? rd2  : rd0;

  ahb_dma_peri_slave #(.MEM_WORDS(40), .WAIT_STATES(0)) u_d0 (
    .clk(clk), .rst(rst), .HSel(hsel & ~sel), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HSize(hsize), .HWData(hwdata), .HWStrb(hwstrb),
    .HReadyIn(hready), .HReadyOut(ro0), .HResp(rsp0), .HRData(rd0),
    .peri_trig(peri_trig), .DmaReq(dma0));

  ahb_dma_peri_slave #(.MEM_WORDS(40), .WAIT_STATES(2)) u_d2 (
    .clk(clk), .rst(rst), .HSel(hsel & sel), .HAddr(haddr), .HTrans(htrans),
    .HWrite(hwrite), .HSize(hsize), .HWData(hwdata), .HWStrb(hwstrb),
    .HReadyIn(hready), .HReadyOut(ro2), .HResp(rsp2), .HRData(rd2),
    .peri_trig(peri_trig), .DmaReq(dma2));

  typedef struct {
    string       name;
    logic [31:0] d;
    bit          chk_d;
    logic [1:0]  resp;
    int          waits;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Wait for a ready cycle, then step past the edge that ends it.
  task automatic wait_ready(input string nm);
    int n = 0;
    forever begin
      @(negedge clk);
      if (hready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL %s ready timeout got 0 expected 1", nm);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input string nm, input logic [7:0] a, input logic wr,
                       input logic [1:0] sz, input logic [31:0] wd, input logic [3:0] st,
                       input logic [31:0] ed, input logic err, input logic push);
    exp_t e;
    hsel = 1'b1; haddr = {24'h0, a}; htrans = 2'b10; hwrite = wr; hsize = sz;
    if (push) begin
      e.name = nm; e.d = ed; e.chk_d = !wr;
`ifdef AHB_DMA_PERI_SLAVE_ERR_EN
      e.resp  = err ? 2'b01 : 2'b00;
      e.waits = err ? 1 : (sel ? 2 : 0);
`else
      e.resp  = 2'b00;
      e.waits = (sel ? 2 : 0) + (err ? 0 : 0);
`endif
      sb.push_back(e);
    end
    wait_ready(nm);
    if (wr) begin hwdata = wd; hwstrb = st; end
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'b00;
    wait_ready("idle");
  endtask

  // Monitor: posedge marks acceptance, negedge counts wait cycles and
  // checks the completing cycle against the head of the scoreboard.
  bit         pend = 0;
  int         waits = 0;
  logic [1:0] lresp = 2'b00;

  always @(posedge clk or negedge clk) begin
    exp_t e;
    if (rst) begin
      pend = 0;
    end else if (clk) begin
      if (hsel && hready && htrans[1]) begin pend = 1; waits = 0; end
    end else if (pend) begin
      if (!hready) begin
        waits++; lresp = hresp;
      end else begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_empty got completion expected none");
        end else begin
          e = sb.pop_front();
          chk({e.name, ".resp"}, 32'(hresp), 32'(e.resp));
          chk({e.name, ".waits"}, 32'(waits), 32'(e.waits));
          if (e.waits > 0) chk({e.name, ".wresp"}, 32'(lresp), 32'(e.resp));
          if (e.chk_d) chk({e.name, ".data"}, hrdata, e.d);
        end
        pend = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    hsel = 0; sel = 0; haddr = 0; htrans = 0; hwrite = 0; hsize = 2'b10;
    hwdata = 0; hwstrb = 0; peri_trig = 0;
    repeat (2) @(posedge clk); #1;
    chk("rst.ready0", 32'(ro0), 32'd1);
    chk("rst.resp0", 32'(rsp0), 32'd0);
    chk("rst.rdata0", rd0, 32'd0);
    chk("rst.dma0", 32'(dma0), 32'd0);
    chk("rst.ready2", 32'(ro2), 32'd1);
    rst = 0;
    @(posedge clk); #1;

    // ---- zero wait-state instance ----
    issue("rdA0_rst", 8'hA0, 0, 2'b10, 0, 0, 32'h0, 0, 1);
    idle();
    issue("wr10", 8'h10, 1, 2'b10, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    issue("rd10", 8'h10, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 1);
    idle();
    issue("wrA0", 8'hA0, 1, 2'b10, 32'h12345678, 4'hF, 0, 0, 1);
    issue("rdA0", 8'hA0, 0, 2'b10, 0, 0, 32'h12345678, 0, 1);
    idle();
    issue("wrA8", 8'hA8, 1, 2'b10, 32'hCCDDEEFF, 4'b1010, 0, 0, 1);
    issue("rdA8", 8'hA8, 0, 2'b10, 0, 0, 32'hCC00EE00, 0, 1);
    idle();
    issue("rdB4", 8'hB4, 0, 2'b10, 0, 0, 32'h0, 1, 1);
    issue("rd02", 8'h02, 0, 2'b10, 0, 0, 32'h0, 1, 1);
    issue("rd10_sz3", 8'h10, 0, 2'b11, 0, 0, 32'h0, 1, 1);
    issue("wr12_bad", 8'h12, 1, 2'b10, 32'hFFFFFFFF, 4'hF, 0, 1, 1);
    idle();
    issue("rd10_keep", 8'h10, 0, 2'b10, 0, 0, 32'hDEADBEEF, 0, 1);
    idle();

    // ---- DMA request ----
    chk("dma.idle", 32'(dma0), 32'd0);
    peri_trig = 1; @(posedge clk); #1; peri_trig = 0;
    chk("dma.set", 32'(dma0), 32'd1);
    @(posedge clk); #1;
    chk("dma.hold", 32'(dma0), 32'd1);
    issue("rdAC", 8'hAC, 0, 2'b10, 0, 0, 32'h0, 0, 1);
    idle();
    chk("dma.clr", 32'(dma0), 32'd0);
    peri_trig = 1; @(posedge clk); #1; peri_trig = 0;
    chk("dma.set2", 32'(dma0), 32'd1);
    issue("rdAC2", 8'hAC, 0, 2'b10, 0, 0, 32'h0, 0, 1);
    peri_trig = 1;
    idle();
    peri_trig = 0;
    chk("dma.setwins", 32'(dma0), 32'd1);

    // ---- two wait-state instance ----
    sel = 1;
    issue("w2_wr00", 8'h00, 1, 2'b10, 32'h11111111, 4'hF, 0, 0, 1);
    idle();
    issue("w2_rd00", 8'h00, 0, 2'b10, 0, 0, 32'h11111111, 0, 1);
    idle();
    issue("w2_wr00s", 8'h00, 1, 2'b10, 32'hAAAA5555, 4'b0011, 0, 0, 1);
    issue("w2_rd00s", 8'h00, 0, 2'b10, 0, 0, 32'h11115555, 0, 1);
    idle();
    issue("w2_rdB4", 8'hB4, 0, 2'b10, 0, 0, 32'h0, 1, 1);
    idle();
    issue("w2_wr20", 8'h20, 1, 2'b10, 32'hCAFEF00D, 4'hF, 0, 0, 1);
    idle();

    // Abort a write in its wait states with reset
    issue("w2_wr20_abort", 8'h20, 1, 2'b10, 32'h0BADBEEF, 4'hF, 0, 0, 0);
    rst = 1; #1;
    chk("abort.ready2", 32'(ro2), 32'd1);
    chk("abort.resp2", 32'(rsp2), 32'd0);
    chk("abort.rdata2", rd2, 32'd0);
    chk("abort.dma0", 32'(dma0), 32'd0);
    hsel = 0; htrans = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    issue("w2_rd20_old", 8'h20, 0, 2'b10, 0, 0, 32'hCAFEF00D, 0, 1);
    idle();

    repeat (3) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
